// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB first, with a registered carry chained between digits.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NUM = WIDTH / DIGIT;
    localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    int unsigned      sh;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] sum_dig;
    logic [DIGIT:0]   chain;
    logic [WIDTH-1:0] acc_nxt;
    logic             last;

    // One digit of ripple-carry full adders fed by the stored carry.
    always_comb begin
        sh       = int'(cnt) * DIGIT;
        a_dig    = DIGIT'(op_a >> sh);
        b_dig    = DIGIT'(op_b >> sh);
        chain    = '0;
        chain[0] = carry;
        sum_dig  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            sum_dig[i]  = a_dig[i] ^ b_dig[i] ^ chain[i];
            chain[i+1]  = (a_dig[i] & b_dig[i])
                        | (chain[i] & (a_dig[i] ^ b_dig[i]));
        end
        acc_nxt = (acc >> DIGIT)
                | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
        last    = (cnt == CW'(NUM - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? ~ci : ci;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    carry <= chain[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // Overflow: carry into the MSB differs from carry out.
                        s     <= acc_nxt;
                        co    <= chain[DIGIT];
                        ovf   <= chain[DIGIT-1] ^ chain[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed literal checks on an 8x1 instance plus a
// randomized model comparison across every DIGIT divisor of 8 and 16.
module tb_serial_adder;

    localparam int NCFG = 9;
    localparam int CFG_W [NCFG] = '{8, 8, 8, 8, 16, 16, 16, 16, 16};
    localparam int CFG_D [NCFG] = '{1, 2, 4, 8, 1, 2, 4, 8, 16};
    localparam int NOPS   = 1200;
    localparam int BUDGET = 40000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rnd_finished = 0;

    // Result packed as s | co<<w | ovf<<(w+1), from plain integer arithmetic.
    function automatic longint ref_op(int w, bit sb, longint ua,
                                      longint ub, bit cin);
        longint mask, half, sa, sbv, r, sr, lo, hi;
        bit     c, v;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sbv  = (ub >= half) ? ub - (longint'(1) << w) : ub;
        lo   = -half;
        hi   = half - 1;
        if (sb) begin
            r  = ua - ub - longint'(cin);
            sr = sa - sbv - longint'(cin);
            c  = (r >= 0);
        end else begin
            r  = ua + ub + longint'(cin);
            sr = sa + sbv + longint'(cin);
            c  = (r > mask);
        end
        v = (sr < lo) || (sr > hi);
        return (r & mask) | (longint'(c) << w) | (longint'(v) << (w + 1));
    endfunction

    task automatic check(input string name, input longint got,
                         input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- directed instance, WIDTH=8 DIGIT=1
    logic       d_rst_n, d_start, d_sub, d_ci;
    logic [7:0] d_a, d_b, d_s;
    logic       d_busy, d_done, d_co, d_ovf;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dir (
        .clk(clk), .rst_n(d_rst_n), .start(d_start), .sub(d_sub),
        .a(d_a), .b(d_b), .ci(d_ci), .busy(d_busy), .done(d_done),
        .s(d_s), .co(d_co), .ovf(d_ovf)
    );

    task automatic run_op(input string name, input bit sb, input logic [7:0] av,
                          input logic [7:0] bv, input bit cv,
                          input logic [9:0] exp);
        int lat, bcnt;
        @(posedge clk);
        #1;
        d_start = 1'b1; d_sub = sb; d_a = av; d_b = bv; d_ci = cv;
        @(posedge clk);
        #1;
        d_start = 1'b0; d_sub = ~sb; d_a = 8'($urandom); d_b = 8'($urandom);
        d_ci = ~cv;
        lat = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (d_busy) bcnt++;
            if (d_done || lat > 40) break;
            @(posedge clk);
            lat++;
        end
        check({name, " latency"}, lat, 8);
        check({name, " busy cycles"}, bcnt, 8);
        check({name, " result"}, {d_ovf, d_co, d_s}, exp);
        @(negedge clk);
        check({name, " done width"}, d_done, 0);
    endtask

    logic [7:0] ba [20];
    logic [7:0] bb [20];
    logic       bs [20];
    logic       bc [20];

    initial begin
        longint r0, r9;
        bit     seen;
        d_rst_n = 1'b0; d_start = 1'b0; d_sub = 1'b0;
        d_a = '0; d_b = '0; d_ci = 1'b0;

        check("model 200+100", ref_op(8, 0, 200, 100, 0), 10'h12C);
        check("model 100+100", ref_op(8, 0, 100, 100, 0), 10'h2C8);
        check("model 5-7",     ref_op(8, 1, 5, 7, 0),     10'h0FE);
        check("model 80-01",   ref_op(8, 1, 8'h80, 1, 0), 10'h37F);
        check("model ff+00+1", ref_op(8, 0, 8'hFF, 0, 1), 10'h100);

        @(negedge clk);
        check("reset outputs", {d_busy, d_done, d_ovf, d_co, d_s}, 0);
        @(posedge clk);
        #1 d_rst_n = 1'b1;

        run_op("add 200+100", 0, 8'd200, 8'd100, 0, 10'h12C);
        run_op("add 100+100", 0, 8'd100, 8'd100, 0, 10'h2C8);
        run_op("sub 5-7",     1, 8'd5,   8'd7,   0, 10'h0FE);
        run_op("sub 80-01",   1, 8'h80,  8'h01,  0, 10'h37F);

        @(posedge clk);
        #1;
        d_start = 1'b1; d_sub = 1'b0; d_a = 8'h55; d_b = 8'h22; d_ci = 1'b0;
        @(posedge clk);
        #1 d_start = 1'b0;
        repeat (2) @(posedge clk);
        #3 d_rst_n = 1'b0;
        #1;
        check("abort outputs", {d_busy, d_done, d_ovf, d_co, d_s}, 0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (d_done) seen = 1'b1;
        end
        d_rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (d_done) seen = 1'b1;
        end
        check("abort no done", seen, 0);
        run_op("add 1+1", 0, 8'd1, 8'd1, 0, 10'h002);

        // start held high while operands change every cycle
        @(posedge clk);
        #1;
        for (int c = 0; c < 20; c++) begin
            d_start = 1'b1;
            ba[c] = 8'($urandom); bb[c] = 8'($urandom);
            bs[c] = 1'($urandom); bc[c] = 1'($urandom);
            d_a = ba[c]; d_b = bb[c]; d_sub = bs[c]; d_ci = bc[c];
            @(posedge clk);
            @(negedge clk);
            r0 = ref_op(8, bs[0], ba[0], bb[0], bc[0]);
            r9 = ref_op(8, bs[9], ba[9], bb[9], bc[9]);
            if (c == 4)
                check("b2b hold s", {d_busy, d_s}, 9'h102);
            if (c == 8)
                check("b2b first", {d_done, d_ovf, d_co, d_s}, {1'b1, r0[9:0]});
            if (c == 12)
                check("b2b hold s2", {d_busy, d_ovf, d_co, d_s},
                      {1'b1, r0[9:0]});
            if (c == 17)
                check("b2b second", {d_done, d_ovf, d_co, d_s}, {1'b1, r9[9:0]});
        end
        d_start = 1'b0;
        repeat (12) @(posedge clk);

        for (int t = 0; t < 60000 && rnd_finished < NCFG; t++)
            @(posedge clk);
        tests++;
        if (rnd_finished < NCFG) begin
            fails++;
            $display("FAIL random timeout: finished %0d, expected %0d",
                     rnd_finished, NCFG);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ---------------- randomized instances with per-cycle model compare
    for (genvar k = 0; k < NCFG; k++) begin : g
        localparam int W = CFG_W[k];
        localparam int D = CFG_D[k];
        localparam int N = W / D;

        logic         rst_n, start, sub, ci;
        logic [W-1:0] a, b, s;
        logic         busy, done, co, ovf;

        serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
            .a(a), .b(b), .ci(ci), .busy(busy), .done(done),
            .s(s), .co(co), .ovf(ovf)
        );

        longint       e = 0;
        longint       fin = -1;
        longint       nacc = 0;
        logic [W-1:0] ms = '0;
        logic         mco = 1'b0;
        logic         movf = 1'b0;
        longint       pend = 0;

        // fin is the edge that completes the pending operation.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fin = -1; ms = '0; mco = 1'b0; movf = 1'b0;
            end else begin
                e++;
                if (e == fin) begin
                    ms = W'(pend); mco = pend[W]; movf = pend[W+1];
                end
                if (e > fin && start) begin
                    pend = ref_op(W, sub, longint'(a), longint'(b), ci);
                    fin  = e + N;
                    nacc++;
                end
            end
        end

        always @(negedge clk) begin
            if ($time > 0) begin
                tests++;
                if ({busy, done, ovf, co, s} !==
                    {(e < fin), (e == fin), movf, mco, ms}) begin
                    fails++;
                    $display("FAIL cfg W%0d D%0d: got b%0b d%0b v%0b c%0b s%0h, expected b%0b d%0b v%0b c%0b s%0h",
                             W, D, busy, done, ovf, co, s,
                             (e < fin), (e == fin), movf, mco, ms);
                end
            end
        end

        initial begin
            int lat, cyc;
            rst_n = 1'b0; start = 1'b0; sub = 1'b0; ci = 1'b0;
            a = '0; b = '0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            start = 1'b1; sub = 1'b0; a = '1; b = '0; ci = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            lat = 0;
            forever begin
                @(negedge clk);
                if (done || lat > 40) break;
                @(posedge clk);
                lat++;
            end
            check($sformatf("W%0d D%0d latency", W, D), lat, N);
            check($sformatf("W%0d D%0d ones+0+1", W, D),
                  {ovf, co, s}, longint'(1) << W);
            cyc = 0;
            while (nacc < NOPS && cyc < BUDGET) begin
                @(posedge clk);
                #1;
                cyc++;
                start = ($urandom % 4) != 0;
                sub   = 1'($urandom);
                ci    = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                if ($urandom % 8 == 0) a = '1;
                if ($urandom % 8 == 0) b = W'(longint'(1) << (W - 1));
                if ($urandom % 300 == 0) begin
                    #2 rst_n = 1'b0;
                    #3 rst_n = 1'b1;
                end
            end
            tests++;
            if (nacc < NOPS) begin
                fails++;
                $display("FAIL W%0d D%0d op budget: got %0d ops, expected %0d",
                         W, D, nacc, NOPS);
            end
            start = 1'b0;
            repeat (N + 2) @(posedge clk);
            rnd_finished++;
        end
    end

endmodule
